// File: rtl/iecdrv_head_track_pkg.sv
// Shared types and constants for the IEC drive head/track controller.
// A save entry is sized for the widest supported half-track number.
package iecdrv_pkg;
    localparam int SAVE_HT_W = 7;

    localparam logic [1:0] STEP_IN  = 2'd1;
    localparam logic [1:0] STEP_OUT = 2'd3;

    typedef struct packed {
        logic [SAVE_HT_W-1:0] htrack;
        logic                 side;
    } save_entry_t;

    localparam int SAVE_ENTRY_W = $bits(save_entry_t);
endpackage

// File: rtl/iecdrv_head_track_if.sv
// Save handshake between the head tracker and the track-buffer/SD engine.
// The tracker is the master: it raises save_req and presents the head entry.
interface iecdrv_head_track_if #(
    parameter int HT_W = 7
);
    logic            save_req;
    logic [HT_W-1:0] save_htrack;
    logic            save_side;
    logic            save_ack;

    modport master (output save_req, save_htrack, save_side, input save_ack);
    modport slave  (input save_req, save_htrack, save_side, output save_ack);
endinterface

// File: rtl/iecdrv_head_track_save_fifo.sv
// Two-entry save FIFO; mem0 is always the head. A push into a full FIFO
// with no pop in the same cycle is dropped and latches the overrun flag.
module iecdrv_save_fifo #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    input  logic         i_clr_ovr,
    output logic         o_valid,
    output logic [W-1:0] o_data,
    output logic         o_overrun
);
    logic [W-1:0] r_mem0, r_mem1;
    logic [1:0]   r_cnt;
    logic         r_ovr;
    logic         w_pop, w_drop, w_wr;

    assign w_pop  = i_pop && (r_cnt != 2'd0);
    assign w_drop = i_push && (r_cnt == 2'd2) && !w_pop;
    assign w_wr   = i_push && !w_drop;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_mem0 <= '0;
            r_mem1 <= '0;
            r_cnt  <= 2'd0;
            r_ovr  <= 1'b0;
        end else begin
            case ({w_wr, w_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) r_mem0 <= i_data;
                    else               r_mem1 <= i_data;
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_mem0 <= r_mem1;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_cnt == 2'd1) begin
                        r_mem0 <= i_data;
                    end else begin
                        r_mem0 <= r_mem1;
                        r_mem1 <= i_data;
                    end
                end
                default: ;
            endcase
            // A new mount starts a clean history, even if a drop coincides.
            if (i_clr_ovr)   r_ovr <= 1'b0;
            else if (w_drop) r_ovr <= 1'b1;
        end
    end

    assign o_valid   = (r_cnt != 2'd0);
    assign o_data    = r_mem0;
    assign o_overrun = r_ovr;
endmodule

// File: rtl/iecdrv_head_track.sv
// Head position, side, settle and disk-change tracking for IEC drive cores;
// queues dirty tracks for saving whenever the head leaves them.
module iecdrv_head_track
    import iecdrv_pkg::*;
#(
    parameter int MAX_HTRACK   = 84,
    parameter int RESET_HTRACK = 36,
    parameter int SIDES        = 1,
    parameter int HT_W         = 7,
    parameter int SETTLE_TICKS = 4096,
    parameter int CHG_W        = 24
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_ce,
    input  logic [1:0]           i_stp,
    input  logic                 i_mtr,
    input  logic                 i_act,
    input  logic                 i_side,
    input  logic                 i_we,
    input  logic                 i_img_mounted,
    input  logic                 i_img_readonly,
    input  logic                 i_img_nonempty,
    output logic [HT_W-1:0]      o_htrack,
    output logic                 o_side,
    output logic                 o_tr00_sense_n,
    output logic                 o_wps_n,
    output logic                 o_disk_present,
    output logic                 o_settled,
    output logic                 o_save_overrun,
    iecdrv_head_track_if.master  save_bus
);
    localparam int SET_W = $clog2(SETTLE_TICKS + 1);

    logic [1:0]       r_stp, r_stp_old, w_move;
    logic [HT_W-1:0]  r_htrack, w_ht_next;
    logic             r_side, w_side_chg, w_ht_chg;
    logic             r_dirty, r_act_old, r_mnt_old;
    logic             w_mnt_rise, w_leave, w_push;
    logic [SET_W-1:0] r_settle;
    logic [CHG_W-1:0] r_chg;
    logic             r_ro, r_present;
    save_entry_t      w_push_entry, w_head;

    // stp is staged once so a phase change is decoded the cycle after it lands.
    assign w_move = r_stp - r_stp_old;

    always_comb begin
        w_ht_next = r_htrack;
        if (i_mtr) begin
            if (w_move == STEP_IN && r_htrack != HT_W'(MAX_HTRACK))
                w_ht_next = r_htrack + HT_W'(1);
            else if (w_move == STEP_OUT && r_htrack != '0)
                w_ht_next = r_htrack - HT_W'(1);
        end
    end

    assign w_ht_chg = (w_ht_next != r_htrack);

    generate
        if (SIDES == 2) begin : g_two_sides
            always_ff @(posedge clk) begin
                if (reset) r_side <= 1'b0;
                else       r_side <= i_side;
            end
            assign w_side_chg = (i_side != r_side);
        end else begin : g_one_side
            logic w_unused_side;
            assign w_unused_side = i_side;
            always_ff @(posedge clk) r_side <= 1'b0;
            assign w_side_chg = 1'b0;
        end
    endgenerate

    assign w_mnt_rise = i_img_mounted && !r_mnt_old;
    assign w_leave    = w_ht_chg || w_side_chg || (r_act_old && !i_act);
    assign w_push     = w_leave && r_dirty;

    // The entry records where the head was, not where it is going.
    always_comb begin
        w_push_entry        = '0;
        w_push_entry.htrack = SAVE_HT_W'(r_htrack);
        w_push_entry.side   = r_side;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stp     <= i_stp;
            r_stp_old <= i_stp;
            r_htrack  <= HT_W'(RESET_HTRACK);
            r_dirty   <= 1'b0;
            r_act_old <= 1'b0;
            r_mnt_old <= 1'b0;
            r_settle  <= '0;
            r_chg     <= '0;
            r_ro      <= 1'b0;
            r_present <= 1'b0;
        end else begin
            r_stp     <= i_stp;
            r_stp_old <= r_stp;
            r_htrack  <= w_ht_next;
            r_act_old <= i_act;
            r_mnt_old <= i_img_mounted;

            if (w_mnt_rise)   r_dirty <= 1'b0;
            else if (i_we)    r_dirty <= 1'b1;
            else if (w_leave) r_dirty <= 1'b0;

            if (w_ht_chg || w_side_chg)
                r_settle <= SET_W'(SETTLE_TICKS);
            else if (i_ce && r_settle != '0)
                r_settle <= r_settle - SET_W'(1);

            if (w_mnt_rise) begin
                r_ro      <= i_img_readonly;
                r_present <= i_img_nonempty;
                r_chg     <= '1;
            end else if (i_ce && r_chg != '0) begin
                r_chg <= r_chg - CHG_W'(1);
            end
        end
    end

    iecdrv_save_fifo #(.W(SAVE_ENTRY_W)) u_save_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_push    (w_push),
        .i_data    (w_push_entry),
        .i_pop     (save_bus.save_ack),
        .i_clr_ovr (w_mnt_rise),
        .o_valid   (save_bus.save_req),
        .o_data    (w_head),
        .o_overrun (o_save_overrun)
    );

    assign save_bus.save_htrack = HT_W'(w_head.htrack);
    assign save_bus.save_side   = w_head.side;

    assign o_htrack       = r_htrack;
    assign o_side         = r_side;
    assign o_tr00_sense_n = |r_htrack;
    // The flicker toggles write-protect so the DOS notices the disk swap.
    assign o_wps_n        = ~r_ro ^ r_chg[CHG_W-2];
    assign o_disk_present = r_present;
    assign o_settled      = (r_settle == '0);
endmodule

// File: tb/tb_iecdrv_head_track.sv
// Randomized scoreboard bench for iecdrv_head_track (two-sided build).
module tb_iecdrv_head_track;
    localparam int HT_W   = 7;
    localparam int MAXH   = 84;
    localparam int RSTH   = 36;
    localparam int SIDES  = 2;
    localparam int SETTLE = 4096;
    localparam int CHG_W  = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst, ce, mtr, act, side_i, we, mnt, ro, ne;
    logic [1:0]      stp;
    logic [HT_W-1:0] htrack;
    logic            side_o, tr00_n, wps_n, present, settled, ovr;

    iecdrv_head_track_if #(.HT_W(HT_W)) bus ();

    iecdrv_head_track #(
        .MAX_HTRACK(MAXH), .RESET_HTRACK(RSTH), .SIDES(SIDES), .HT_W(HT_W),
        .SETTLE_TICKS(SETTLE), .CHG_W(CHG_W)
    ) dut (
        .clk(clk), .reset(rst), .i_ce(ce), .i_stp(stp), .i_mtr(mtr), .i_act(act),
        .i_side(side_i), .i_we(we), .i_img_mounted(mnt), .i_img_readonly(ro),
        .i_img_nonempty(ne), .o_htrack(htrack), .o_side(side_o),
        .o_tr00_sense_n(tr00_n), .o_wps_n(wps_n), .o_disk_present(present),
        .o_settled(settled), .o_save_overrun(ovr), .save_bus(bus)
    );

    typedef struct { int ht; bit side; } ent_t;
    typedef struct { int ht; bit side, tr00, settled, wps, pres, req, ovr; } snap_t;

    ent_t  exp_q[$];
    snap_t sq[$];
    int    vectors = 0;
    int    errors  = 0;
    bit    ack_en  = 1'b0;

    // Reference model state: what the drive mechanics should look like.
    int       m_ht, m_settle, m_chg, m_n;
    bit       m_side, m_dirty, m_ovr, m_ro, m_pres, m_act_prev, m_mnt_prev;
    bit [1:0] m_stp_prev2, m_stp_prev1;

    task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_step();
        int mv, nht;
        bit sch, leave, popped, push;
        if (rst) begin
            m_ht = RSTH; m_side = 0; m_dirty = 0; m_n = 0; m_ovr = 0;
            m_settle = 0; m_chg = 0; m_ro = 0; m_pres = 0;
            m_act_prev = 0; m_mnt_prev = 0;
            m_stp_prev2 = stp; m_stp_prev1 = stp;
            exp_q.delete();
            return;
        end
        mv  = (int'(m_stp_prev1) - int'(m_stp_prev2) + 4) % 4;
        nht = m_ht;
        if (mtr && mv == 1 && m_ht < MAXH) nht = m_ht + 1;
        if (mtr && mv == 3 && m_ht > 0)    nht = m_ht - 1;
        sch    = (side_i != m_side);
        leave  = (nht != m_ht) || sch || (m_act_prev && !act);
        popped = bus.save_ack && (m_n > 0);
        push   = leave && m_dirty;
        if (popped) m_n--;
        if (mnt && !m_mnt_prev) m_ovr = 0;
        if (push) begin
            if (m_n < 2) begin
                m_n++;
                exp_q.push_back('{ht: m_ht, side: m_side});
            end else if (!(mnt && !m_mnt_prev)) begin
                m_ovr = 1;
            end
        end
        if (mnt && !m_mnt_prev) m_dirty = 0;
        else if (we)            m_dirty = 1;
        else if (leave)         m_dirty = 0;
        if (nht != m_ht || sch)       m_settle = SETTLE;
        else if (ce && m_settle > 0)  m_settle--;
        if (mnt && !m_mnt_prev) begin
            m_ro = ro; m_pres = ne; m_chg = (1 << CHG_W) - 1;
        end else if (ce && m_chg > 0) begin
            m_chg--;
        end
        m_ht = nht;
        m_side = side_i;
        m_stp_prev2 = m_stp_prev1;
        m_stp_prev1 = stp;
        m_act_prev = act;
        m_mnt_prev = mnt;
    endtask

    task automatic cycle(int n = 1);
        snap_t s;
        repeat (n) begin
            bus.save_ack = !rst && ack_en && ($urandom_range(2) == 0);
            model_step();
            @(posedge clk);
            #1;
            s.ht = m_ht; s.side = m_side; s.tr00 = (m_ht != 0);
            s.settled = (m_settle == 0);
            s.wps = (!m_ro) ^ (((m_chg >> (CHG_W - 2)) & 1) != 0);
            s.pres = m_pres; s.req = (m_n > 0); s.ovr = m_ovr;
            sq.push_back(s);
        end
    endtask

    task automatic step(int dir, int n);
        repeat (n) begin
            stp = stp + 2'(dir);
            cycle(2);
        end
    endtask

    task automatic pulse_we();
        we = 1; cycle(1); we = 0;
    endtask

    // Monitor: per-cycle state plus save transactions as the engine accepts them.
    snap_t ms;
    ent_t  me;
    initial begin
        forever begin
            @(negedge clk);
            if (sq.size() > 0) begin
                ms = sq.pop_front();
                chk("htrack",       32'(htrack),       32'(ms.ht));
                chk("side_o",       32'(side_o),       32'(ms.side));
                chk("tr00_sense_n", 32'(tr00_n),       32'(ms.tr00));
                chk("settled",      32'(settled),      32'(ms.settled));
                chk("wps_n",        32'(wps_n),        32'(ms.wps));
                chk("disk_present", 32'(present),      32'(ms.pres));
                chk("save_req",     32'(bus.save_req), 32'(ms.req));
                chk("save_overrun", 32'(ovr),          32'(ms.ovr));
            end
            if (bus.save_req === 1'b1 && bus.save_ack === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("save_unexpected", 32'(bus.save_htrack), 32'hFFFF_FFFF);
                end else begin
                    me = exp_q.pop_front();
                    chk("save_htrack", 32'(bus.save_htrack), 32'(me.ht));
                    chk("save_side",   32'(bus.save_side),   32'(me.side));
                end
            end
        end
    end

    initial begin
        rst = 1; ce = 0; stp = 2'd2; mtr = 0; act = 0; side_i = 0; we = 0;
        mnt = 0; ro = 0; ne = 0; bus.save_ack = 0;
        cycle(3);
        rst = 0;
        cycle(2);

        // Three steps in from the reset track, then wait out the settle time.
        mtr = 1; ce = 1;
        step(1, 3);
        cycle(SETTLE + 20);

        // Step out past track 0, then a skipped phase that must be ignored.
        step(3, 45);
        stp = stp + 2'd2; cycle(4);

        // Dirty track 40, leave it, then let the engine acknowledge.
        step(1, 40);
        pulse_we();
        step(1, 1);
        cycle(2);
        ack_en = 1; cycle(12); ack_en = 0;

        // Queue two side-change saves and overflow with a third.
        pulse_we(); side_i = 1; cycle(2);
        pulse_we(); side_i = 0; cycle(2);
        pulse_we(); side_i = 1; cycle(3);
        ack_en = 1; cycle(20); ack_en = 0;

        // Activity stop: save once, then not again when clean.
        act = 1; pulse_we(); cycle(1);
        act = 0; cycle(3);
        act = 1; cycle(2); act = 0; cycle(3);
        ack_en = 1; cycle(10);

        // Read-only, empty image mount: watch the write-protect flicker.
        ro = 1; ne = 0; mnt = 1; cycle(1); mnt = 0;
        cycle(300);

        // Saturate at the top half-track while writing.
        we = 1; step(1, 50); we = 0;
        cycle(4);

        // Reset while a save is pending.
        ack_en = 0;
        pulse_we(); step(3, 1); cycle(2);
        rst = 1; cycle(2); rst = 0; cycle(3);

        // Random traffic.
        ack_en = 1;
        repeat (3000) begin
            ce = $urandom_range(1);
            mtr = ($urandom_range(7) != 0);
            we = ($urandom_range(5) == 0);
            if ($urandom_range(3) == 0) act = ~act;
            if ($urandom_range(15) == 0) side_i = ~side_i;
            case ($urandom_range(7))
                0, 1: stp = stp + 2'd1;
                2, 3: stp = stp + 2'd3;
                4:    stp = stp + 2'd2;
                default: ;
            endcase
            mnt = ($urandom_range(199) == 0);
            ro = $urandom_range(1);
            ne = $urandom_range(1);
            cycle(1);
        end

        // Quiesce and drain every queued save.
        mtr = 0; we = 0; mnt = 0;
        cycle(40);
        @(negedge clk); #1;
        chk("drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/iecdrv_head_track.md
Name: iecdrv_head_track

Overview:
- Parametrised head-position and track-dirty controller for IEC drive emulations: 1541, 1571 double-sided, and 40/42-track images.
- Decodes the two-phase stepper from the drive logic and maintains the half-track number and active side.
- Drives tr00_sense_n and the disk-change write-protect flicker.
- Issues a req/ack save handshake to the track-buffer/SD engine whenever a modified track is left or activity stops.
- Sits between the drive logic and the GCR/track-loader blocks in the core clock domain.

Parameters:
- MAX_HTRACK, 84, highest legal half-track index (0-based).
- RESET_HTRACK, 36, half-track loaded on reset (track 18).
- SIDES, 1, number of heads (1 or 2).
- HT_W, 7, width of the half-track number.
- SETTLE_TICKS, 4096, ce ticks that settled stays low after each step or side change.
- CHG_W, 24, width of the disk-change timeout counter.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high
- ce  in  1  drive clock enable (1 MHz-equivalent tick)
- stp  in  2  stepper phase from the drive VIA
- mtr  in  1  spindle motor on
- act  in  1  drive activity LED
- side_i  in  1  head select (ignored when SIDES=1)
- we  in  1  GCR write strobe (marks the current track dirty)
- img_mounted  in  1  mount pulse/level; rising edge is used
- img_readonly  in  1  image read-only, sampled on the mount edge
- img_nonempty  in  1  image size non-zero, sampled on the mount edge
- htrack  out  HT_W  current half-track
- side_o  out  1  current side
- tr00_sense_n  out  1  low when htrack==0
- wps_n  out  1  write-protect sense to the drive logic
- disk_present  out  1  latched img_nonempty
- settled  out  1  head not moving
- save_req  out  1  save request, held until acknowledged
- save_htrack  out  HT_W  half-track to save
- save_side  out  1  side to save
- save_ack  in  1  one-cycle acknowledge from the track engine
- save_overrun  out  1  sticky: a save was lost

Behaviour:
- Reset values:
  - htrack=RESET_HTRACK, side_o=0
  - dirty=0, save_req=0, save_htrack=0, save_side=0, save_overrun=0
  - settled=1, disk_present=0, change counter=0
  - stp_old loaded from stp, so no spurious step
- Stepper decoding, every clk:
  - move = stp - stp_old, modulo 4.
  - When mtr=1 and move==1: htrack increments, saturating at MAX_HTRACK.
  - When mtr=1 and move==3: htrack decrements, saturating at 0.
  - move==2 (skipped phase) is ignored. mtr=0 ignores all moves, but stp_old still tracks stp.
  - Step takes effect the cycle after stp changes; htrack is registered one cycle later (2-cycle latency).
- Side:
  - SIDES=2: side_o follows side_i one cycle late. A change counts as a "leave" event.
  - SIDES=1: side_o is tied 0.
- Dirty tracking:
  - we=1 sets dirty. A rising edge of img_mounted clears dirty and save_overrun.
  - Leave events:
    - an accepted step that actually changes htrack (a saturated step is not a leave);
    - a side change;
    - act falling with dirty=1.
  - On a leave event with dirty=1: the pre-change htrack/side_o go to the save slot and dirty clears in the same cycle.
  - we in the same cycle as a leave marks the new track dirty.
- Save handshake, 2-entry FIFO:
  - save_req=1 whenever the FIFO is non-empty; save_htrack/save_side show the head entry.
  - save_ack pops the head entry. A push and a pop in the same cycle are both honoured.
  - A push to a full FIFO drops the new entry and sets save_overrun.
  - An ack while the FIFO is empty is ignored.
- Settle:
  - Any htrack or side change reloads a down-counter to SETTLE_TICKS, decremented on ce; settled = (counter==0).
  - A new step mid-settle reloads the counter.
- Disk change:
  - On the img_mounted rising edge: latch readonly and disk_present, load the change counter with all ones.
  - The counter decrements on ce until 0.
  - wps_n = ~readonly XOR counter[CHG_W-2].
- tr00_sense_n = |htrack (combinational from the register).
- Reset mid-save: the FIFO is flushed and save_req drops the next cycle; the track engine must tolerate a missing ack.

Decomposition:
- Package iecdrv_pkg:
  - typedef save_entry_t {htrack, side};
  - constants for step codes (STEP_IN=1, STEP_OUT=3).
- One sub-module, iecdrv_save_fifo: 2-entry FIFO with push/pop/overrun, parametrised on entry width.

Test Plan:
1. Reset, then mtr=1, stp 0→1→2→3 → htrack 36→37→38→39; tr00_sense_n=1; settled low 4096 ce ticks after the last step.
2. mtr=1, htrack=1, stp 3→2→1 → htrack 0 then stays 0; tr00_sense_n=0; no save pushed. stp 0→2 → no change.
3. we pulse on htrack=40, step in → save_req=1, save_htrack=40, save_side=0, dirty cleared. save_ack → save_req=0 next cycle.
4. SIDES=2: dirty on side0/ht20 and side1/ht20 with side toggles, no ack → 2 entries queued in order. A third dirty leave → save_overrun=1, the queued entries keep their values.
5. Dirty track, act 1→0 → a single save request for the current track. A second act fall without we → no request.
6. img_mounted edge with img_readonly=1 → wps_n toggles as counter bit CHG_W-2 flips, then settles at 0; img_nonempty=0 → disk_present=0.
